// File: rtl/pipibibs_snd_latch.sv
// PiPiBiBi 68000-to-Z80 sound command FIFO with SOUNDLATCH head register and Z80 IRQ handshake.
// Define PIPIBIBS_SND_REPLY_EN to add the Z80-to-68k reply latch with pending flag.
module pipibibs_snd_latch #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic       CLK96,
   input  logic       RESET96,
   input  logic       M68K_WR,
   input  logic [7:0] M68K_DIN,
   output logic [7:0] M68K_STATUS,
   input  logic       M68K_OVF_CLR,
   input  logic       Z80_RD,
   output logic [7:0] SOUNDLATCH,
   output logic       Z80_INT_N,
   input  logic       Z80_IACK,
   input  logic       Z80_WR,
   input  logic [7:0] Z80_DIN,
   input  logic       M68K_RD_REPLY,
   output logic [7:0] M68K_REPLY
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ACKED} intState_t;

   intState_t     r_state, w_stateNext;
   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wptr, r_rptr, w_rptrNext;
   logic [AW:0]   r_count, w_countNext;
   logic [7:0]    r_soundLatch, w_headNext;
   logic          r_wrD, r_rdD, r_iackD;
   logic          r_full, r_empty, r_ovf;
   logic          w_push, w_pop, w_iack, w_pushOk, w_popOk, w_ovfSet;
   logic          w_replyPend;

   always_ff @(posedge CLK96 or posedge RESET96) begin
      if (RESET96) begin
         r_wrD   <= 1'b0;
         r_rdD   <= 1'b0;
         r_iackD <= 1'b0;
      end else begin
         r_wrD   <= M68K_WR;
         r_rdD   <= Z80_RD;
         r_iackD <= Z80_IACK;
      end
   end

   assign w_push = M68K_WR && !r_wrD;
   assign w_pop  = Z80_RD && !r_rdD;
   assign w_iack = Z80_IACK && !r_iackD;

   // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
   assign w_popOk    = w_pop && (r_count != '0);
   assign w_pushOk   = w_push && ((r_count != FULL_CNT) || w_popOk);
   assign w_ovfSet   = w_push && !w_pushOk;
   assign w_rptrNext = w_popOk ? r_rptr + AW'(1) : r_rptr;

   always_comb begin
      w_countNext = r_count;
      if (w_pushOk && !w_popOk)
         w_countNext = r_count + (AW+1)'(1);
      else if (!w_pushOk && w_popOk)
         w_countNext = r_count - (AW+1)'(1);
   end

   // Bypass the byte being written when it lands in the slot that becomes the new head.
   always_comb begin
      w_headNext = r_mem[w_rptrNext];
      if (w_pushOk && (r_wptr == w_rptrNext))
         w_headNext = M68K_DIN;
   end

   always_ff @(posedge CLK96) begin
      if (w_pushOk)
         r_mem[r_wptr] <= M68K_DIN;
   end

   always_ff @(posedge CLK96 or posedge RESET96) begin
      if (RESET96) begin
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_count      <= '0;
         r_soundLatch <= 8'hFF;
         r_full       <= 1'b0;
         r_empty      <= 1'b1;
         r_ovf        <= 1'b0;
      end else begin
         if (w_pushOk)
            r_wptr <= r_wptr + AW'(1);
         r_rptr  <= w_rptrNext;
         r_count <= w_countNext;
         if (w_countNext != '0)
            r_soundLatch <= w_headNext;
         r_full  <= (w_countNext == FULL_CNT);
         r_empty <= (w_countNext == '0);
         if (w_ovfSet)
            r_ovf <= 1'b1;
         else if (M68K_OVF_CLR)
            r_ovf <= 1'b0;
      end
   end

   always_ff @(posedge CLK96 or posedge RESET96) begin
      if (RESET96)
         r_state <= ST_IDLE;
      else
         r_state <= w_stateNext;
   end

   // A Z80 that drains the FIFO without acknowledging also drops the request.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         ST_IDLE:
            if (w_countNext != '0)
               w_stateNext = ST_REQ;
         ST_REQ:
            if (w_countNext == '0)
               w_stateNext = ST_IDLE;
            else if (w_iack)
               w_stateNext = ST_ACKED;
         ST_ACKED:
            if (w_countNext == '0)
               w_stateNext = ST_IDLE;
            else if (w_popOk)
               w_stateNext = ST_REQ;
         default:
            w_stateNext = ST_IDLE;
      endcase
   end

`ifdef PIPIBIBS_SND_REPLY_EN
   logic       r_z80WrD, r_m68kRdD, r_replyPend;
   logic [7:0] r_reply;

   always_ff @(posedge CLK96 or posedge RESET96) begin
      if (RESET96) begin
         r_z80WrD    <= 1'b0;
         r_m68kRdD   <= 1'b0;
         r_replyPend <= 1'b0;
         r_reply     <= 8'h00;
      end else begin
         r_z80WrD  <= Z80_WR;
         r_m68kRdD <= M68K_RD_REPLY;
         if (Z80_WR && !r_z80WrD) begin
            r_reply     <= Z80_DIN;
            r_replyPend <= 1'b1;
         end else if (M68K_RD_REPLY && !r_m68kRdD) begin
            r_replyPend <= 1'b0;
         end
      end
   end

   assign M68K_REPLY  = r_reply;
   assign w_replyPend = r_replyPend;
`else
   logic w_unusedReply;
   assign w_unusedReply = ^{Z80_WR, Z80_DIN, M68K_RD_REPLY};
   assign M68K_REPLY    = 8'h00;
   assign w_replyPend   = 1'b0;
`endif

   assign SOUNDLATCH  = r_soundLatch;
   assign Z80_INT_N   = (r_state != ST_REQ);
   assign M68K_STATUS = {4'b0000, w_replyPend, r_ovf, r_empty, r_full};

endmodule

// File: doc/pipibibs_snd_latch.md
Name: pipibibs_snd_latch

Overview:
- Command path between the 68000 main CPU and the Z80 sound CPU in the PiPiBiBi's audio subsystem.
- Buffers 68k command bytes in a small FIFO and presents the head byte as SOUNDLATCH to the sound block.
- Raises a Z80 interrupt request while commands are pending and pops one byte per Z80 read.
- Optionally provides a Z80-to-68k reply latch with a pending flag.

Parameters:
- DEPTH, 4: FIFO entries; must be a power of two, 2..16.
- AW, 2: pointer width; must equal log2(DEPTH).

Ports:
- CLK96  in  1  system clock; all logic is clocked on its rising edge.
- RESET96  in  1  asynchronous reset, active-high.
- M68K_WR  in  1  68k command-write strobe; level, may span many cycles.
- M68K_DIN  in  8  68k command byte.
- M68K_STATUS  out  8  68k status: bit0 = full, bit1 = empty, bit2 = overflow sticky, bit3 = reply pending, bits7:4 = 0.
- M68K_OVF_CLR  in  1  one-cycle pulse; clears the overflow sticky.
- Z80_RD  in  1  Z80 latch-read strobe (IORQ/MREQ decode & !rd_n); level.
- SOUNDLATCH  out  8  FIFO head byte to the Z80 data mux.
- Z80_INT_N  out  1  active-low interrupt request to the Z80.
- Z80_IACK  in  1  Z80 interrupt acknowledge (!m1_n & !iorq_n); level.
- Z80_WR  in  1  Z80 reply-write strobe; used only with the optional feature.
- Z80_DIN  in  8  Z80 reply byte; used only with the optional feature.
- M68K_RD_REPLY  in  1  68k reply-read strobe; used only with the optional feature.
- M68K_REPLY  out  8  reply byte to the 68k; used only with the optional feature.

Behaviour:
- Reset values:
  - Pointers and count = 0.
  - SOUNDLATCH = 8'hFF.
  - Z80_INT_N = 1.
  - M68K_STATUS = 8'h02.
  - Overflow sticky = 0.
  - M68K_REPLY = 8'h00.
- Strobe detection: all strobes are rising-edge detected, using a registered copy of each strobe. A strobe held high counts as exactly one event.
- Push:
  - On a M68K_WR rising edge with count < DEPTH: write M68K_DIN at wptr, then wptr++ and count++.
  - When full: drop the byte and set overflow sticky. Pointers and count are unchanged.
- Pop:
  - On a Z80_RD rising edge with count > 0: rptr++ and count--.
  - When empty: no pointer or count change. SOUNDLATCH keeps its last value; this is not an error.
- SOUNDLATCH:
  - Registered; always equals mem[rptr] one cycle after any pointer or count change.
  - The Z80 samples the current head during the read, and the pop takes effect after the edge.
- Simultaneous push and pop in the same cycle:
  - count unchanged, both pointers advance.
  - Allowed even when full: the pop frees the slot first, so no overflow.
  - When empty, the push is accepted and the pop is ignored.
- Pointer wrap: pointers wrap modulo DEPTH. count is AW+1 bits wide.
- Status: full = (count == DEPTH), empty = (count == 0). Both are registered from next-state, so there is no lag after a push or pop.
- Interrupt state machine:
  - IDLE -> REQ when count becomes non-zero. In REQ, Z80_INT_N = 0.
  - REQ -> ACKED on a Z80_IACK rising edge. Z80_INT_N returns to 1.
  - ACKED -> IDLE when count == 0.
  - ACKED -> REQ on a Z80_RD pop that leaves count > 0, so the next command interrupts again.
  - Reset mid-REQ returns the machine to IDLE immediately (asynchronous).
- M68K_OVF_CLR coincident with an overflow event: set wins.
- Latency: push to Z80_INT_N low = 1 cycle. Push to SOUNDLATCH valid (from empty) = 1 cycle.

Optional Feature:
- Macro: PIPIBIBS_SND_REPLY_EN.
- Defined:
  - Z80_WR rising edge loads Z80_DIN into M68K_REPLY and sets reply pending (status bit3).
  - M68K_RD_REPLY rising edge clears pending.
  - Write and read in the same cycle: write wins, pending = 1.
- Undefined:
  - Reply register removed.
  - M68K_REPLY tied to 8'h00 and status bit3 = 0.
  - Z80_WR, Z80_DIN and M68K_RD_REPLY ignored.

Test Plan:
- Reset, then write 8'h12 (M68K_WR held 5 cycles) -> exactly one entry, SOUNDLATCH = 8'h12 and Z80_INT_N = 0 one cycle later, status = 8'h00.
- Write 8'h01..8'h05 with DEPTH = 4 -> status bit0 = 1 after the 4th, 5th byte dropped, bit2 = 1. Four Z80 reads return 01,02,03,04, then status = 8'h06. M68K_OVF_CLR -> status = 8'h02.
- Fill to 4, then push 8'hAA and pop in the same cycle -> no overflow, count stays 4. Drain gives 02,03,04,AA, proving wrap-around.
- Push 2 bytes, pulse Z80_IACK -> Z80_INT_N = 1. Pop one -> Z80_INT_N = 0 again. Pop the last -> state IDLE, Z80_INT_N = 1.
- Assert RESET96 mid-operation with 3 entries and Z80_INT_N = 0 -> outputs return to reset values immediately, without waiting for a clock edge.
- With PIPIBIBS_SND_REPLY_EN: Z80 writes 8'h5A -> M68K_REPLY = 8'h5A, bit3 = 1. 68k read -> bit3 = 0. Without the macro: M68K_REPLY stays 8'h00.
